// File: rtl/ker_stream_tx.sv
// Kernel weight stream transmitter: serializes wide host-bus words into STR_KER_WIDTH
// words on a valid/ready stream. Optional macro KER_TX_MSB_FIRST_EN sends the highest lane first.
module ker_stream_tx #(
    parameter int                    CFG_DWIDTH    = 32,
    parameter int                    CFG_AWIDTH    = 5,
    parameter logic [CFG_AWIDTH-1:0] CFG_KER_TX    = 5'd12,
    parameter int                    BUS_WIDTH     = 64,
    parameter int                    STR_KER_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CFG_DWIDTH-1:0]    cfg_data,
    input  logic [CFG_AWIDTH-1:0]    cfg_addr,
    input  logic                     cfg_valid,
    input  logic [BUS_WIDTH-1:0]     bus_data,
    input  logic                     bus_val,
    output logic                     bus_rdy,
    output logic [STR_KER_WIDTH-1:0] str_ker,
    output logic                     str_ker_val,
    input  logic                     str_ker_rdy,
    output logic                     busy,
    output logic                     done
);
    localparam int LANES = BUS_WIDTH / STR_KER_WIDTH;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int W     = STR_KER_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [15:0]            remain_q, remain_d;
    logic [15:0]            fetch_q, fetch_d;
    logic [BUS_WIDTH-1:0]   buf_q, buf_d;
    logic [LW-1:0]          lane_q, lane_d;
    logic [LW-1:0]          last_q, last_d;
    logic                   full_q, full_d;
    logic [W-1:0]           out_q, out_d;
    logic                   val_q, val_d;

    logic [W-1:0]           buf_lane [LANES];
    logic [W-1:0]           bus_lane0;
    logic                   out_free, advance, last_adv, bus_rdy_c, bus_hs, str_hs;
    logic [15:0]            take;
    logic                   unused_cfg;

    assign unused_cfg = ^cfg_data[CFG_DWIDTH-1:16];

    // Lane 0 is always the first word to leave, whichever end of the bus word it sits at.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef KER_TX_MSB_FIRST_EN
            assign buf_lane[gi] = buf_q[BUS_WIDTH-1-gi*W -: W];
`else
            assign buf_lane[gi] = buf_q[gi*W +: W];
`endif
        end
    endgenerate

`ifdef KER_TX_MSB_FIRST_EN
    assign bus_lane0 = bus_data[BUS_WIDTH-1 -: W];
`else
    assign bus_lane0 = bus_data[W-1:0];
`endif

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        fetch_d  = fetch_q;
        buf_d    = buf_q;
        lane_d   = lane_q;
        last_d   = last_q;
        full_d   = full_q;
        out_d    = out_q;
        val_d    = val_q;

        out_free  = !val_q || str_ker_rdy;
        advance   = full_q && out_free;
        last_adv  = advance && (lane_q == last_q);
        bus_rdy_c = (state_q == S_RUN) && (fetch_q != 16'd0) && (!full_q || last_adv);
        bus_hs    = bus_val && bus_rdy_c;
        str_hs    = val_q && str_ker_rdy;
        take      = (fetch_q >= 16'(LANES)) ? 16'(LANES) : fetch_q;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid && (cfg_addr == CFG_KER_TX) && (cfg_data[15:0] != 16'd0)) begin
                    state_d  = S_RUN;
                    remain_d = cfg_data[15:0];
                    fetch_d  = cfg_data[15:0];
                    lane_d   = '0;
                    full_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (str_hs) begin
                    remain_d = remain_q - 16'd1;
                    if (remain_q == 16'd1) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (str_hs) val_d = 1'b0;

        if (advance) begin
            out_d  = buf_lane[lane_q];
            val_d  = 1'b1;
            lane_d = lane_q + 1'b1;
            if (lane_q == last_q) full_d = 1'b0;
        end

        // A word arriving while the output is free bypasses straight to lane 0,
        // so the first kernel word appears the cycle after the host handshake.
        if (bus_hs) begin
            buf_d   = bus_data;
            fetch_d = fetch_q - take;
            last_d  = LW'(take - 16'd1);
            if (!full_q && out_free) begin
                out_d  = bus_lane0;
                val_d  = 1'b1;
                lane_d = LW'(1);
                full_d = (take > 16'd1);
            end else begin
                lane_d = '0;
                full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            remain_q <= '0;
            fetch_q  <= '0;
            buf_q    <= '0;
            lane_q   <= '0;
            last_q   <= '0;
            full_q   <= 1'b0;
            out_q    <= '0;
            val_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            fetch_q  <= fetch_d;
            buf_q    <= buf_d;
            lane_q   <= lane_d;
            last_q   <= last_d;
            full_q   <= full_d;
            out_q    <= out_d;
            val_q    <= val_d;
        end
    end

    assign bus_rdy     = bus_rdy_c;
    assign str_ker     = out_q;
    assign str_ker_val = val_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_ker_stream_tx.sv
// Directed bench for ker_stream_tx with a queue-based reference model checked every cycle.
module tb_ker_stream_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfg_data = '0;
    logic [4:0]  cfg_addr = '0;
    logic        cfg_valid = 1'b0;
    logic [63:0] bus_data = '0;
    logic        bus_val = 1'b0;
    logic        bus_rdy;
    logic [15:0] str_ker;
    logic        str_ker_val;
    logic        str_ker_rdy = 1'b1;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    ker_stream_tx dut (
        .clk(clk), .rst(rst),
        .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
        .bus_data(bus_data), .bus_val(bus_val), .bus_rdy(bus_rdy),
        .str_ker(str_ker), .str_ker_val(str_ker_val), .str_ker_rdy(str_ker_rdy),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference model: expected outputs derived from N and the host words accepted.
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          hs_cyc[$];
    int          cyc = 0;
    int          done_cnt = 0;
    logic        m_busy = 0, m_done = 0, prev_rst = 0, prev_stall = 0;
    logic [15:0] prev_data = '0;
    int          m_rem = 0, m_push = 0;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            cyc++;
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (m_push == 0) chk("bus_rdy_idle", bus_rdy, 0);
            if (!m_busy) chk("val_idle", str_ker_val, 0);
            if (prev_rst) begin
                chk("rst_str_ker", str_ker, 0);
                chk("rst_val", str_ker_val, 0);
                chk("rst_bus_rdy", bus_rdy, 0);
            end
            if (prev_stall) begin
                chk("stall_val", str_ker_val, 1);
                chk("stall_data", str_ker, prev_data);
            end
            prev_stall = str_ker_val && !str_ker_rdy && !rst;
            prev_data  = str_ker;
            prev_rst   = rst;
            if (rst) begin
                m_busy = 0; m_done = 0; m_rem = 0; m_push = 0;
                exp_q.delete();
            end else begin
                logic nb, nd;
                nb = m_busy; nd = 0;
                if (done) done_cnt++;
                if (m_done) nb = 0;
                if (str_ker_val && str_ker_rdy) begin
                    $display("tx word %0h at cycle %0d", str_ker, cyc);
                    got_q.push_back(str_ker);
                    hs_cyc.push_back(cyc);
                    if (exp_q.size() == 0 || m_rem == 0) begin
                        chk("extra_output", 1, 0);
                    end else begin
                        chk("str_ker", str_ker, exp_q.pop_front());
                        if (m_rem == 1) nd = 1;
                        m_rem--;
                    end
                end
                if (bus_val && bus_rdy) begin
                    if (m_push == 0) chk("extra_host_word", 1, 0);
                    for (int i = 0; i < 4 && m_push > 0; i++) begin
`ifdef KER_TX_MSB_FIRST_EN
                        exp_q.push_back(bus_data[63-16*i -: 16]);
`else
                        exp_q.push_back(bus_data[16*i +: 16]);
`endif
                        m_push--;
                    end
                end
                if (!m_busy && cfg_valid && cfg_addr == 5'd12 && cfg_data[15:0] != 0) begin
                    nb = 1;
                    m_rem = int'(cfg_data[15:0]);
                    m_push = m_rem;
                end
                m_busy = nb; m_done = nd;
            end
        end
    end

    localparam logic [63:0] W1 = 64'h0004_0003_0002_0001;
    localparam logic [63:0] W2 = 64'h0008_0007_0006_0005;

    task automatic arm(input logic [15:0] n);
        cfg_addr = 5'd12; cfg_data = {16'hA5A5, n}; cfg_valid = 1'b1;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic host_send(input logic [63:0] w, input int gap);
        logic ok;
        ok = 0;
        bus_data = w; bus_val = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus_rdy) begin ok = 1; break; end
        end
        if (!ok) chk("host_timeout", 0, 1);
        @(posedge clk); #1;
        bus_val = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 0;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) chk("idle_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_list(input string nm, input logic [15:0] lit[$]);
        chk({nm, "_count"}, got_q.size(), lit.size());
        for (int i = 0; i < lit.size() && i < got_q.size(); i++)
            chk(nm, got_q[i], lit[i]);
    endtask

    logic [15:0] lit[$];
    logic        stop_tog;
    int          dsave;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Full 8-word transfer, back-to-back.
        got_q.delete(); hs_cyc.delete(); done_cnt = 0;
        arm(16'd8);
        @(negedge clk);
        chk("t1_busy_after_arm", busy, 1);
        chk("t1_bus_rdy_after_arm", bus_rdy, 1);
        @(posedge clk); #1;
        host_send(W1, 0);
        host_send(W2, 0);
        wait_idle();
`ifdef KER_TX_MSB_FIRST_EN
        lit = '{16'd4, 16'd3, 16'd2, 16'd1, 16'd8, 16'd7, 16'd6, 16'd5};
`else
        lit = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
`endif
        check_list("t1_seq", lit);
        if (hs_cyc.size() == 8) chk("t1_consecutive", hs_cyc[7] - hs_cyc[0], 7);
        chk("t1_done_pulses", done_cnt, 1);

        // Partial last word: N=6.
        got_q.delete(); done_cnt = 0;
        arm(16'd6);
        host_send(W1, 0);
        host_send(W2, 0);
        wait_idle();
`ifdef KER_TX_MSB_FIRST_EN
        lit = '{16'd4, 16'd3, 16'd2, 16'd1, 16'd8, 16'd7};
`else
        lit = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
`endif
        check_list("t2_seq", lit);
        chk("t2_done_pulses", done_cnt, 1);

        // Backpressure toggling and gapped host words.
        got_q.delete(); done_cnt = 0; stop_tog = 0;
        arm(16'd8);
        fork
            begin
                host_send(W1, 3);
                host_send(W2, 0);
                wait_idle();
                stop_tog = 1;
            end
            begin
                for (int t = 0; t < 600 && !stop_tog; t++) begin
                    @(posedge clk); #1;
                    str_ker_rdy = ~str_ker_rdy;
                end
            end
        join
        str_ker_rdy = 1'b1;
`ifdef KER_TX_MSB_FIRST_EN
        lit = '{16'd4, 16'd3, 16'd2, 16'd1, 16'd8, 16'd7, 16'd6, 16'd5};
`else
        lit = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
`endif
        check_list("t3_seq", lit);
        chk("t3_done_pulses", done_cnt, 1);

        // Ignored arms: N=0 in IDLE, and N=3 while busy.
        got_q.delete(); done_cnt = 0;
        arm(16'd0);
        @(negedge clk);
        chk("t4_n0_busy", busy, 0);
        @(posedge clk); #1;
        arm(16'd5);
        arm(16'd3);
        @(negedge clk);
        chk("t4_busy_kept", busy, 1);
        @(posedge clk); #1;
        host_send(W1, 0);
        host_send(W2, 0);
        wait_idle();
`ifdef KER_TX_MSB_FIRST_EN
        lit = '{16'd4, 16'd3, 16'd2, 16'd1, 16'd8};
`else
        lit = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
`endif
        check_list("t4_seq", lit);

        // Reset after three of eight words, then a clean re-arm.
        got_q.delete(); done_cnt = 0;
        arm(16'd8);
        host_send(W1, 0);
        for (int t = 0; t < 50; t++) begin
            @(posedge clk); #1;
            if (got_q.size() >= 3) break;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_busy_after_rst", busy, 0);
        chk("t5_val_after_rst", str_ker_val, 0);
        @(posedge clk); #1;
        dsave = done_cnt;
        chk("t5_no_done", dsave, 0);
        got_q.delete();
        arm(16'd4);
        host_send(W1, 0);
        wait_idle();
`ifdef KER_TX_MSB_FIRST_EN
        lit = '{16'd4, 16'd3, 16'd2, 16'd1};
`else
        lit = '{16'd1, 16'd2, 16'd3, 16'd4};
`endif
        check_list("t5_seq", lit);
        chk("t5_done_pulses", done_cnt, 1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
